// File: rtl/kernel3_gmem_b_m_axi_mem_reader_pkg.sv
//==============================================================================
// Module   : kernel3_gmem_b_m_axi_mem_reader_pkg
// Brief    : Shared constants, types and helpers for the gmem_B read controller.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package kernel3_gmem_b_m_axi_mem_reader_pkg;

   // Words that may be outstanding between issue and consumer.
   localparam int unsigned CREDIT_LIMIT = 4;

   // rd_en: cycle after issue (RAM read enable); data_vld: RAM data out valid.
   typedef struct packed {
      logic rd_en;
      logic data_vld;
   } stage_vld_t;

   // Usable range is 0..depth-2, which is not a power of two.
   function automatic int unsigned next_rptr(input int unsigned ptr, input int unsigned depth);
      return (ptr >= depth - 2) ? 0 : ptr + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/kernel3_gmem_b_m_axi_mem_reader_if.sv
//==============================================================================
// Module   : kernel3_gmem_b_m_axi_mem_reader_if
// Brief    : Writer, buffer-RAM read port and output stream of the reader.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface kernel3_gmem_b_m_axi_mem_reader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
);
   logic                  push;
   logic                  full;
   logic [ADDR_WIDTH:0]   used;
   logic                  mem_clk_en;
   logic [ADDR_WIDTH-1:0] mem_raddr;
   logic                  mem_re;
   logic [DATA_WIDTH-1:0] mem_dout;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  err;

   modport master (
      input  push, mem_dout, m_ready,
      output full, used, mem_clk_en, mem_raddr, mem_re, m_valid, m_data, err
   );

   modport slave (
      output push, mem_dout, m_ready,
      input  full, used, mem_clk_en, mem_raddr, mem_re, m_valid, m_data, err
   );
endinterface

`default_nettype wire

// File: rtl/kernel3_gmem_b_m_axi_mem_reader_obuf.sv
//==============================================================================
// Module   : kernel3_gmem_b_m_axi_mem_reader_obuf
// Brief    : 4-entry in-order register FIFO; head drives the output stream.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module kernel3_gmem_b_m_axi_mem_reader_obuf #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_wr_en,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_ready,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [2:0]            o_count
);
   logic [DATA_WIDTH-1:0] r_mem [4];
   logic [1:0]            r_wptr;
   logic [1:0]            r_rptr;
   logic [2:0]            r_count;
   logic                  w_pop;

   assign w_pop   = (r_count != 3'd0) && i_ready;
   assign o_valid = (r_count != 3'd0);
   assign o_data  = r_mem[r_rptr];
   assign o_count = r_count;

   // No full guard: the issuer's credit check bounds occupancy to four.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            r_mem[i] <= '0;
         end
         r_wptr  <= 2'd0;
         r_rptr  <= 2'd0;
         r_count <= 3'd0;
      end else begin
         if (i_wr_en) begin
            r_mem[r_wptr] <= i_wr_data;
            r_wptr        <= r_wptr + 2'd1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 2'd1;
         end
         case ({i_wr_en, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

`default_nettype wire

// File: rtl/kernel3_gmem_b_m_axi_mem_reader.sv
//==============================================================================
// Module   : kernel3_gmem_b_m_axi_mem_reader
// Brief    : Read-side controller for the gmem_B buffer RAM (2-cycle latency).
// Macro    : KERNEL3_GMEM_B_OVERFLOW_CHECK_EN builds the sticky overflow flag.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module kernel3_gmem_b_m_axi_mem_reader
   import kernel3_gmem_b_m_axi_mem_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int DEPTH      = 63
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   kernel3_gmem_b_m_axi_mem_reader_if.master    bus
);
   localparam logic [ADDR_WIDTH:0] C_FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] C_ONE        = (ADDR_WIDTH + 1)'(1);

   logic [ADDR_WIDTH:0]   r_used;
   logic [ADDR_WIDTH-1:0] r_rptr;
   stage_vld_t            r_stage;
   logic                  r_clk_en;
   logic [2:0]            w_obuf_count;
   logic [3:0]            w_credit_used;
   logic                  w_full;
   logic                  w_push_ok;
   logic                  w_issue;

   always_comb begin
      w_full        = (r_used == C_FULL_LEVEL);
      w_push_ok     = bus.push && !w_full;
      w_credit_used = 4'(r_stage.rd_en) + 4'(r_stage.data_vld) + 4'(w_obuf_count);
      w_issue       = (r_used != '0) && (w_credit_used < 4'(CREDIT_LIMIT));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_used   <= '0;
         r_rptr   <= '0;
         r_stage  <= '0;
         r_clk_en <= 1'b0;
      end else begin
         r_clk_en         <= 1'b1;
         r_stage.rd_en    <= w_issue;
         r_stage.data_vld <= r_stage.rd_en;
         if (w_issue) begin
            r_rptr <= ADDR_WIDTH'(next_rptr(32'(r_rptr), DEPTH));
         end
         case ({w_push_ok, w_issue})
            2'b10:   r_used <= r_used + C_ONE;
            2'b01:   r_used <= r_used - C_ONE;
            default: r_used <= r_used;
         endcase
      end
   end

   assign bus.full       = w_full;
   assign bus.used       = r_used;
   assign bus.mem_clk_en = r_clk_en;
   assign bus.mem_raddr  = r_rptr;
   assign bus.mem_re     = r_stage.rd_en;

   kernel3_gmem_b_m_axi_mem_reader_obuf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_obuf (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_wr_en   (r_stage.data_vld),
      .i_wr_data (bus.mem_dout),
      .i_ready   (bus.m_ready),
      .o_valid   (bus.m_valid),
      .o_data    (bus.m_data),
      .o_count   (w_obuf_count)
   );

`ifdef KERNEL3_GMEM_B_OVERFLOW_CHECK_EN
   logic r_err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err <= 1'b0;
      end else if (bus.push && w_full) begin
         r_err <= 1'b1;
      end
   end

   assign bus.err = r_err;
`else
   assign bus.err = 1'b0;
`endif
endmodule

`default_nettype wire
